// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional even/odd parity, one stop bit.
// The serial line is synchronized and then sampled at the middle of each bit.
// The outputs rx_valid, parity_err and frame_err are registered single-cycle pulses.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic           PAR_EN    = (PARITY_EN != 0);
   localparam logic           ODD_BIT   = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t          state;
   logic [CW-1:0]   baud_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift_reg;
   logic            mismatch;
   logic            sync1;
   logic            sync2;
   logic            line;

   assign line = sync2;
   assign busy = (state != IDLE);

   // Two-flop synchronizer; it resets to the idle (high) line level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= serial_in;
         sync2 <= sync1;
      end
   end

   // Frame state machine; the start bit is confirmed at its middle and every later bit is sampled one bit period after that.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         mismatch   <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         unique case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (!line) begin
                  mismatch <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (baud_cnt == BAUD_HALF) begin
                  baud_cnt <= '0;
                  state    <= line ? IDLE : DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt           <= '0;
                  shift_reg[bit_cnt] <= line;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
                     state   <= PAR_EN ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            PARITY: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  mismatch <= ((^shift_reg) ^ line) != ODD_BIT;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt   <= '0;
                  rx_data    <= shift_reg;
                  rx_valid   <= 1'b1;
                  parity_err <= mismatch;
                  frame_err  <= !line;
                  state      <= line ? IDLE : WAIT_HIGH;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            WAIT_HIGH: begin
               baud_cnt <= '0;
               if (line) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit with even parity.
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk;
   logic       rst;
   logic       serial_in;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   int         vectors;
   int         miscompares;
   int         cycle_count;
   int         pulse_count;
   int         pulse_cycle;
   int         start_cycle;
   int         prev_count;
   logic       busy_seen;
   logic [7:0] got_data [0:15];
   logic       got_perr [0:15];
   logic       got_ferr [0:15];

   uart_rx #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN(1),
      .PARITY_ODD(0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .serial_in(serial_in),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .parity_err(parity_err),
      .frame_err(frame_err),
      .busy(busy)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Free-running cycle counter used for latency measurement
   always @(posedge clk) begin
      cycle_count <= cycle_count + 1;
   end

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Record every output pulse away from the active edge and police stray error flags
   always @(negedge clk) begin
      if (busy === 1'b1) busy_seen = 1'b1;
      if (rx_valid === 1'b1) begin
         if (pulse_count < 16) begin
            got_data[pulse_count] = rx_data;
            got_perr[pulse_count] = parity_err;
            got_ferr[pulse_count] = frame_err;
         end
         pulse_cycle = cycle_count;
         pulse_count++;
      end
      if (parity_err === 1'b1 || frame_err === 1'b1) begin
         checkOutput("flag_without_valid", {31'd0, rx_valid}, 32'd1);
      end
   end

   // Hold the line at one level for one bit period, leaving time at posedge+1
   task automatic driveBit(input logic b);
      serial_in = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   // Send one complete frame: start, 8 data bits LSB first, parity, stop
   task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stop);
      start_cycle = cycle_count;
      driveBit(1'b0);
      for (int i = 0; i < 8; i++) driveBit(d[i]);
      driveBit(par);
      driveBit(stop);
   endtask

   // Check the most recently recorded frame against expected values
   task automatic checkFrame(input string tag, input int idx, input logic [7:0] d, input logic pe, input logic fe);
      checkOutput({tag, "_data"}, {24'd0, got_data[idx]}, {24'd0, d});
      checkOutput({tag, "_perr"}, {31'd0, got_perr[idx]}, {31'd0, pe});
      checkOutput({tag, "_ferr"}, {31'd0, got_ferr[idx]}, {31'd0, fe});
   endtask

   initial begin
      logic [7:0] partial;
      int         latency;
      vectors     = 0;
      miscompares = 0;
      cycle_count = 0;
      pulse_count = 0;
      pulse_cycle = 0;
      start_cycle = 0;
      busy_seen   = 1'b0;
      rst         = 1'b1;
      serial_in   = 1'b1;

      // Reset values before any clock edge
      #1;
      checkOutput("reset_rx_data", {24'd0, rx_data}, 32'h00);
      checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      checkOutput("reset_parity_err", {31'd0, parity_err}, 32'd0);
      checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      repeat (2) driveBit(1'b1);

      // Clean frame 0xA5, even parity 0
      $display("[TB] frame 0xA5");
      prev_count = pulse_count;
      applyStimulus(8'hA5, 1'b0, 1'b1);
      driveBit(1'b1);
      latency = pulse_cycle - start_cycle;
      checkOutput("a5_count", pulse_count, prev_count + 1);
      checkOutput("a5_latency_in_window", {31'd0, (latency >= 169 && latency <= 171)}, 32'd1);
      checkFrame("a5", prev_count, 8'hA5, 1'b0, 1'b0);

      // Frame 0x3C with a wrong (odd) parity bit
      $display("[TB] frame 0x3C bad parity");
      prev_count = pulse_count;
      applyStimulus(8'h3C, 1'b1, 1'b1);
      driveBit(1'b1);
      checkOutput("3c_count", pulse_count, prev_count + 1);
      checkFrame("3c", prev_count, 8'h3C, 1'b1, 1'b0);

      // Frame 0x55 with stop bit 0 and the line held low 40 cycles
      $display("[TB] frame 0x55 framing error");
      prev_count = pulse_count;
      applyStimulus(8'h55, 1'b0, 1'b0);
      serial_in = 1'b0;
      repeat (24) @(posedge clk);
      #1;
      checkOutput("55_busy_while_low", {31'd0, busy}, 32'd1);
      driveBit(1'b1);
      driveBit(1'b1);
      checkOutput("55_busy_after_high", {31'd0, busy}, 32'd0);
      checkOutput("55_count", pulse_count, prev_count + 1);
      checkFrame("55", prev_count, 8'h55, 1'b0, 1'b1);

      // Four-cycle low glitch on the idle line
      $display("[TB] glitch");
      prev_count = pulse_count;
      busy_seen  = 1'b0;
      serial_in  = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      driveBit(1'b1);
      driveBit(1'b1);
      checkOutput("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
      checkOutput("glitch_count", pulse_count, prev_count);
      checkOutput("glitch_rx_data", {24'd0, rx_data}, 32'h55);

      // Back-to-back frames 0x00 then 0xFF
      $display("[TB] back-to-back 0x00 0xFF");
      prev_count = pulse_count;
      applyStimulus(8'h00, 1'b0, 1'b1);
      applyStimulus(8'hFF, 1'b0, 1'b1);
      driveBit(1'b1);
      checkOutput("b2b_count", pulse_count, prev_count + 2);
      checkFrame("b2b_first", prev_count, 8'h00, 1'b0, 1'b0);
      checkFrame("b2b_second", prev_count + 1, 8'hFF, 1'b0, 1'b0);

      // Reset asserted during data bit 4 of a 0xC3 frame
      $display("[TB] reset mid-frame");
      prev_count = pulse_count;
      partial    = 8'hC3;
      driveBit(1'b0);
      for (int i = 0; i < 4; i++) driveBit(partial[i]);
      serial_in = partial[4];
      repeat (5) @(posedge clk);
      #2;
      rst       = 1'b1;
      serial_in = 1'b1;
      #1;
      checkOutput("midrst_rx_data", {24'd0, rx_data}, 32'h00);
      checkOutput("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      repeat (3) driveBit(1'b1);
      checkOutput("midrst_count", pulse_count, prev_count);
      checkOutput("midrst_busy_after", {31'd0, busy}, 32'd0);

      // Clean 0x81 frame after the reset
      $display("[TB] frame 0x81 after reset");
      prev_count = pulse_count;
      applyStimulus(8'h81, 1'b0, 1'b1);
      driveBit(1'b1);
      checkOutput("81_count", pulse_count, prev_count + 1);
      checkFrame("81", prev_count, 8'h81, 1'b0, 1'b0);
      checkOutput("81_rx_data_held", {24'd0, rx_data}, 32'h81);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
